// File: rtl/seg_fault_sequencer_pkg.sv
// Shared state encodings, default constants and segment IDs for the segment-fault
// sequencer and the AG-stage limit checker.
package seg_fault_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_REDIRECT = 2'b11
    } seq_state_e;

    typedef enum logic [2:0] {
        SEG_ES = 3'b000,
        SEG_CS = 3'b001,
        SEG_SS = 3'b010,
        SEG_DS = 3'b011,
        SEG_FS = 3'b100,
        SEG_GS = 3'b101
    } seg_id_e;

    localparam logic [31:0] GP_HANDLER_EIP_DEF = 32'h0000_0D00;
    localparam logic [7:0]  GP_VECTOR_DEF      = 8'd13;
    localparam int unsigned DRAIN_W            = 4;

endpackage

// File: rtl/seg_fault_drain_ctr.sv
// 4-bit loadable down-counter; o_term flags the last drain cycle (count == 1).
module seg_fault_drain_ctr
    import seg_fault_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [DRAIN_W-1:0] i_load_val,
    input  logic               i_en,
    output logic               o_term
);

    logic [DRAIN_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_term = (r_count == DRAIN_W'(1));

endmodule

// File: rtl/seg_fault_sequencer.sv
// #GP sequencer for AG-stage segment limit faults: stall, drain, flush, redirect.
// Optional macro SEG_FAULT_CNT_EN adds a saturating FAULT_CNT redirect counter.
module seg_fault_sequencer
    import seg_fault_sequencer_pkg::*;
#(
    parameter int unsigned  DRAIN_CYCLES   = 3,
    parameter logic [31:0]  GP_HANDLER_EIP = GP_HANDLER_EIP_DEF,
    parameter logic [7:0]   GP_VECTOR      = GP_VECTOR_DEF
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        V_AG,
    input  logic        EXC_SEG,
    input  logic        STALL_AG,
    input  logic [31:0] EIP_AG,
    input  logic        DOWN_STALL,
    output logic        FE_STALL,
    output logic        FLUSH,
    output logic        LD_EIP,
    output logic [31:0] HANDLER_EIP,
    output logic [31:0] FAULT_EIP,
    output logic [7:0]  FAULT_VEC,
    output logic        FAULT_PEND
`ifdef SEG_FAULT_CNT_EN
    ,
    output logic [15:0] FAULT_CNT
`endif
);

    seq_state_e  r_state;
    seq_state_e  w_next;
    logic        w_cap;
    logic        w_drain_en;
    logic        w_drain_last;
    logic [31:0] r_handler_eip;
    logic [31:0] r_fault_eip;
    logic [7:0]  r_fault_vec;
    logic        r_fault_pend;

    assign w_cap      = (r_state == ST_IDLE) & V_AG & EXC_SEG & ~STALL_AG;
    assign w_drain_en = (r_state == ST_DRAIN) & ~DOWN_STALL;

    seg_fault_drain_ctr u_drain_ctr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_cap),
        .i_load_val (DRAIN_W'(DRAIN_CYCLES)),
        .i_en       (w_drain_en),
        .o_term     (w_drain_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_cap) w_next = ST_DRAIN;
            ST_DRAIN:    if (w_drain_last && !DOWN_STALL) w_next = ST_FLUSH;
            ST_FLUSH:    w_next = ST_REDIRECT;
            ST_REDIRECT: w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // The cap term holds the faulting instruction in AG during the capture cycle.
    always_comb begin
        FE_STALL = w_cap | (r_state == ST_DRAIN) | (r_state == ST_FLUSH);
        FLUSH    = (r_state == ST_FLUSH);
        LD_EIP   = (r_state == ST_REDIRECT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fault_eip   <= '0;
            r_fault_vec   <= '0;
            r_fault_pend  <= 1'b0;
            r_handler_eip <= '0;
        end else begin
            if (w_cap) begin
                r_fault_eip  <= EIP_AG;
                r_fault_vec  <= GP_VECTOR;
                r_fault_pend <= 1'b1;
            end else if (r_state == ST_REDIRECT) begin
                r_fault_pend <= 1'b0;
            end
            r_handler_eip <= (w_next == ST_REDIRECT) ? GP_HANDLER_EIP : '0;
        end
    end

    assign HANDLER_EIP = r_handler_eip;
    assign FAULT_EIP   = r_fault_eip;
    assign FAULT_VEC   = r_fault_vec;
    assign FAULT_PEND  = r_fault_pend;

`ifdef SEG_FAULT_CNT_EN
    logic [15:0] r_fault_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fault_cnt <= '0;
        end else if ((r_state == ST_REDIRECT) && (r_fault_cnt != '1)) begin
            r_fault_cnt <= r_fault_cnt + 1'b1;
        end
    end

    assign FAULT_CNT = r_fault_cnt;
`endif

endmodule

// File: tb/tb_seg_fault_sequencer.sv
// Scoreboard bench for seg_fault_sequencer: the stimulus side predicts each cycle's
// outputs from the fault timeline, a monitor compares them against the DUT.
module tb_seg_fault_sequencer;

    localparam int unsigned D     = 3;
    localparam logic [31:0] H_EIP = 32'h0000_0D00;
    localparam logic [7:0]  VEC   = 8'd13;
    localparam int          MAXC  = 4096;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        V_AG = 1'b0;
    logic        EXC_SEG = 1'b0;
    logic        STALL_AG = 1'b0;
    logic [31:0] EIP_AG = '0;
    logic        DOWN_STALL = 1'b0;
    logic        FE_STALL, FLUSH, LD_EIP, FAULT_PEND;
    logic [31:0] HANDLER_EIP, FAULT_EIP;
    logic [7:0]  FAULT_VEC;
`ifdef SEG_FAULT_CNT_EN
    logic [15:0] FAULT_CNT;
`endif

    seg_fault_sequencer #(
        .DRAIN_CYCLES   (D),
        .GP_HANDLER_EIP (H_EIP),
        .GP_VECTOR      (VEC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .V_AG        (V_AG),
        .EXC_SEG     (EXC_SEG),
        .STALL_AG    (STALL_AG),
        .EIP_AG      (EIP_AG),
        .DOWN_STALL  (DOWN_STALL),
        .FE_STALL    (FE_STALL),
        .FLUSH       (FLUSH),
        .LD_EIP      (LD_EIP),
        .HANDLER_EIP (HANDLER_EIP),
        .FAULT_EIP   (FAULT_EIP),
        .FAULT_VEC   (FAULT_VEC),
        .FAULT_PEND  (FAULT_PEND)
`ifdef SEG_FAULT_CNT_EN
        ,
        .FAULT_CNT   (FAULT_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic        fe;
        logic        fl;
        logic        ld;
        logic        pend;
        logic [31:0] heip;
        logic [31:0] feip;
        logic [7:0]  fvec;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   ds[MAXC];
    int   cyc = 0;

    // Fault timeline: cycle of capture, of the FLUSH pulse and of the LD_EIP pulse.
    bit          active = 1'b0;
    int          cap_cyc = 0;
    int          flush_cyc = 0;
    int          redir_cyc = 0;
    logic [31:0] m_feip = '0;
    logic [7:0]  m_fvec = '0;
    logic [15:0] m_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs, queue the prediction.
    task automatic step(input bit rst, input logic v, input logic e, input logic s, input logic [31:0] eip);
        exp_t x;
        bit   cap;
        int   k;
        int   zeros;
        @(negedge CLK);
        if (!rst) RST = 1'b0;
        V_AG       = rst ? 1'b0 : v;
        EXC_SEG    = e;
        STALL_AG   = s;
        EIP_AG     = eip;
        DOWN_STALL = ds[cyc];
        x.cyc = cyc;
        if (rst) begin
            #1 RST = 1'b1;
            active = 1'b0;
            m_feip = '0;
            m_fvec = '0;
            m_cnt  = '0;
            x.fe = 1'b0; x.fl = 1'b0; x.ld = 1'b0; x.pend = 1'b0;
            x.heip = '0; x.feip = '0; x.fvec = '0; x.cnt = '0;
        end else begin
            cap = !(active && cyc <= redir_cyc) && v && e && !s;
            if (cap) begin
                // FLUSH follows the cycle in which the D-th non-stalled drain cycle falls.
                cap_cyc = cyc;
                zeros   = 0;
                k       = cyc;
                while (zeros < int'(D) && k < MAXC - 3) begin
                    k++;
                    if (!ds[k]) zeros++;
                end
                flush_cyc = k + 1;
                redir_cyc = k + 2;
                active    = 1'b1;
            end
            x.fe   = cap || (active && cyc > cap_cyc && cyc <= flush_cyc);
            x.fl   = active && cyc == flush_cyc;
            x.ld   = active && cyc == redir_cyc;
            x.pend = active && cyc > cap_cyc && cyc <= redir_cyc;
            x.heip = x.ld ? H_EIP : 32'h0;
            x.feip = m_feip;
            x.fvec = m_fvec;
            x.cnt  = m_cnt;
            if (cap) begin
                m_feip = eip;
                m_fvec = VEC;
            end
            if (x.ld && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        sb.push_back(x);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge CLK);
            #3;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("FE_STALL",    {31'b0, FE_STALL},   {31'b0, x.fe},   x.cyc);
                check("FLUSH",       {31'b0, FLUSH},      {31'b0, x.fl},   x.cyc);
                check("LD_EIP",      {31'b0, LD_EIP},     {31'b0, x.ld},   x.cyc);
                check("FAULT_PEND",  {31'b0, FAULT_PEND}, {31'b0, x.pend}, x.cyc);
                check("HANDLER_EIP", HANDLER_EIP,         x.heip,          x.cyc);
                check("FAULT_EIP",   FAULT_EIP,           x.feip,          x.cyc);
                check("FAULT_VEC",   {24'b0, FAULT_VEC},  {24'b0, x.fvec}, x.cyc);
`ifdef SEG_FAULT_CNT_EN
                check("FAULT_CNT",   {16'b0, FAULT_CNT},  {16'b0, x.cnt},  x.cyc);
`endif
            end
        end
    end

    initial begin : stimulus
        int c;
        for (int i = 0; i < MAXC; i++) ds[i] = ($urandom_range(0, 9) < 3);
        for (int i = 0; i < 100; i++) ds[i] = 1'b0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);

        // EXC_SEG without a valid instruction, or with AG stalled, is ignored.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA_0001);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0002);
        idle(1);

        // Basic fault, then a back-to-back fault right after REDIRECT.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1234);
        idle(5);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_5678);
        idle(7);

        // Downstream stall for two drain cycles, with a second EXC_SEG during DRAIN.
        c = cyc;
        ds[c + 2] = 1'b1;
        ds[c + 3] = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_9ABC);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle(8);

        // Asynchronous reset in the middle of DRAIN, then a fresh fault.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1111);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2222);
        idle(8);

`ifdef SEG_FAULT_CNT_EN
        @(posedge CLK);
        #1 force dut.r_fault_cnt = 16'hFFFF;
        #1 release dut.r_fault_cnt;
        m_cnt = 16'hFFFF;
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3333);
        idle(8);
`endif

        repeat (600) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 2),
                 $urandom);
        end

        repeat (3) @(negedge CLK);
        #5;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
